pll_rst_sequencer: RTL and testbench

- Drives the `rst` input of the 50 MHz-referenced PLL (25 MHz VGA pixel clock, 12.288 MHz audio clock) and consumes its `locked` output.
- Holds the PLL in reset for a fixed time, waits for lock with a timeout and bounded retries, then requires lock to stay stable before releasing the downstream system reset.
- Re-sequences automatically on loss of lock.
- Runs entirely in the `refclk` domain.

---
 rtl/pll_rst_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_rst_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_sequencer.sv
// Purpose: PLL reset/lock sequencer. Pulses pll_rst, waits for lock with timeout and retries, and releases sys_rst once lock is stable.
// Latency: ready rises LOCK_STABLE_CYCLES+3 refclk edges after pll_locked rises in WAIT_LOCK (2 sync flops + state register).
// Backpressure: none; the block is purely level driven. `PLL_RST_SEQ_LOSS_CNT_EN adds a saturating loss_count output.
module pll_rst_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 8,
    parameter int unsigned CNT_W              = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [3:0] retry_count,
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    output logic [7:0] loss_count,
`endif
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lk_meta;
    logic             lk_s;
    logic [3:0]       retry_inc;

    assign retry_inc = retry_count + 4'd1;

    // Outputs are assigned alongside each state transition so they switch on the same edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= S_HOLD;
            cnt         <= '0;
            lk_meta     <= 1'b0;
            lk_s        <= 1'b0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            retry_count <= 4'd0;
            timeout_err <= 1'b0;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
            loss_count  <= 8'd0;
`endif
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;

            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    // Lock takes priority over a coincident timeout.
                    if (lk_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_count <= retry_inc;
                        cnt         <= '0;
                        pll_rst     <= 1'b1;
                        if (retry_inc == RETRY_LIMIT) begin
                            state       <= S_FAIL;
                            timeout_err <= 1'b1;
                        end else begin
                            state <= S_HOLD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STABLE: begin
                    if (!lk_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= S_RUN;
                        cnt         <= '0;
                        retry_count <= 4'd0;
                        sys_rst     <= 1'b0;
                        ready       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (!lk_s) begin
                        state   <= S_HOLD;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
                        if (loss_count != 8'hFF) begin
                            loss_count <= loss_count + 8'd1;
                        end
`endif
                    end
                end

                default: begin
                    // Terminal until rst.
                    state   <= S_FAIL;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Directed bench for pll_rst_sequencer with small timing parameters (hold 4, timeout 20, stable 8, retries 3).
module tb_pll_rst_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [3:0] retry_count;
    logic       timeout_err;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic [7:0] loss_count;
`endif

    int checks = 0;
    int errors = 0;

    pll_rst_sequencer #(
        .RST_HOLD_CYCLES   (4),
        .LOCK_TIMEOUT      (20),
        .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES       (3),
        .CNT_W             (17)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .retry_count(retry_count),
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        .loss_count (loss_count),
`endif
        .timeout_err(timeout_err)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset pulse spanning one edge; returns just after "edge 0" with rst low.
    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;

        // ---- Reset state ----
        tick(2);
        check("rst_pll_rst", 8'(pll_rst), 8'd1);
        check("rst_sys_rst", 8'(sys_rst), 8'd1);
        check("rst_ready", 8'(ready), 8'd0);
        check("rst_retry", 8'(retry_count), 8'd0);
        check("rst_terr", 8'(timeout_err), 8'd0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        check("rst_loss", loss_count, 8'd0);
`endif

        // ---- Normal lock: pll_rst high for exactly 4 edges ----
        rst = 1'b0;
        tick(3);
        check("norm_pll_rst_e3", 8'(pll_rst), 8'd1);
        tick(1);
        check("norm_pll_rst_e4", 8'(pll_rst), 8'd0);
        check("norm_sys_rst_e4", 8'(sys_rst), 8'd1);
        tick(6);
        pll_locked = 1'b1;                      // after edge 10
        tick(10);
        check("norm_ready_e20", 8'(ready), 8'd0);
        check("norm_sys_rst_e20", 8'(sys_rst), 8'd1);
        tick(1);
        check("norm_ready_e21", 8'(ready), 8'd1);
        check("norm_sys_rst_e21", 8'(sys_rst), 8'd0);
        check("norm_pll_rst_e21", 8'(pll_rst), 8'd0);
        check("norm_retry_e21", 8'(retry_count), 8'd0);

        // ---- Loss of lock in RUN: 3-cycle drop ----
        pll_locked = 1'b0;                      // after edge 21
        tick(2);
        check("loss_ready_e23", 8'(ready), 8'd1);
        tick(1);
        check("loss_ready_e24", 8'(ready), 8'd0);
        check("loss_sys_rst_e24", 8'(sys_rst), 8'd1);
        check("loss_pll_rst_e24", 8'(pll_rst), 8'd1);
        check("loss_retry_e24", 8'(retry_count), 8'd0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        check("loss_count", loss_count, 8'd1);
`endif
        pll_locked = 1'b1;
        tick(3);
        check("loss_pll_rst_e27", 8'(pll_rst), 8'd1);
        tick(1);
        check("loss_pll_rst_e28", 8'(pll_rst), 8'd0);
        tick(8);
        check("loss_ready_e36", 8'(ready), 8'd0);
        tick(1);
        check("loss_ready_e37", 8'(ready), 8'd1);
        check("loss_sys_rst_e37", 8'(sys_rst), 8'd0);

        // ---- Single timeout then lock ----
        pll_locked = 1'b0;
        do_reset();
        tick(23);
        check("to_pll_rst_e23", 8'(pll_rst), 8'd0);
        check("to_retry_e23", 8'(retry_count), 8'd0);
        tick(1);
        check("to_pll_rst_e24", 8'(pll_rst), 8'd1);
        check("to_retry_e24", 8'(retry_count), 8'd1);
        tick(3);
        check("to_pll_rst_e27", 8'(pll_rst), 8'd1);
        tick(1);
        check("to_pll_rst_e28", 8'(pll_rst), 8'd0);
        check("to_retry_e28", 8'(retry_count), 8'd1);
        pll_locked = 1'b1;                      // after edge 28
        tick(10);
        check("to_ready_e38", 8'(ready), 8'd0);
        check("to_retry_e38", 8'(retry_count), 8'd1);
        tick(1);
        check("to_ready_e39", 8'(ready), 8'd1);
        check("to_retry_e39", 8'(retry_count), 8'd0);
        check("to_sys_rst_e39", 8'(sys_rst), 8'd0);

        // ---- One-cycle lock glitch in STABLE (STABLE entered at edge 5) ----
        pll_locked = 1'b1;
        do_reset();
        tick(8);
        pll_locked = 1'b0;                      // after edge 8
        tick(1);
        pll_locked = 1'b1;                      // after edge 9
        tick(2);
        check("gl_pll_rst_e11", 8'(pll_rst), 8'd0);
        check("gl_ready_e11", 8'(ready), 8'd0);
        tick(2);
        check("gl_ready_e13", 8'(ready), 8'd0);
        tick(6);
        check("gl_ready_e19", 8'(ready), 8'd0);
        check("gl_pll_rst_e19", 8'(pll_rst), 8'd0);
        tick(1);
        check("gl_ready_e20", 8'(ready), 8'd1);

        // ---- FAIL after 3 timeouts ----
        pll_locked = 1'b0;
        do_reset();
        tick(71);
        check("fail_retry_e71", 8'(retry_count), 8'd2);
        check("fail_terr_e71", 8'(timeout_err), 8'd0);
        check("fail_pll_rst_e71", 8'(pll_rst), 8'd0);
        tick(1);
        check("fail_terr_e72", 8'(timeout_err), 8'd1);
        check("fail_pll_rst_e72", 8'(pll_rst), 8'd1);
        check("fail_sys_rst_e72", 8'(sys_rst), 8'd1);
        check("fail_ready_e72", 8'(ready), 8'd0);
        check("fail_retry_e72", 8'(retry_count), 8'd3);
        for (int i = 0; i < 200; i++) begin
            tick(1);
            check("fail_static", {pll_rst, sys_rst, ready, timeout_err, retry_count}, 8'b1101_0011);
        end

        // Async reset clears sticky timeout_err without a clock edge.
        rst = 1'b1;
        #2;
        check("arst_terr", 8'(timeout_err), 8'd0);
        check("arst_retry", 8'(retry_count), 8'd0);
        check("arst_pll_rst", 8'(pll_rst), 8'd1);
        tick(1);
        rst = 1'b0;

        // ---- Async reset mid-STABLE ----
        pll_locked = 1'b1;
        do_reset();
        tick(7);
        check("st_pll_rst_e7", 8'(pll_rst), 8'd0);
        check("st_ready_e7", 8'(ready), 8'd0);
        rst = 1'b1;
        #2;
        check("st_arst_pll_rst", 8'(pll_rst), 8'd1);
        check("st_arst_sys_rst", 8'(sys_rst), 8'd1);
        check("st_arst_ready", 8'(ready), 8'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
